// File: rtl/fifo_acc_drain_pkg.sv
// fifo_acc_drain_pkg: shared types and defaults for the accumulator-FIFO drain controller.
//   state_t    : controller states (IDLE, DRAIN, HOLD)
//   *_W_DEF    : default widths for the top-level parameters
//   zext()     : zero extension of a word to an arbitrary width (up to ZEXT_MAX_W)
package fifo_acc_drain_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ACC_W_DEF   = 40;
  localparam int unsigned COUNT_W_DEF = 4;

  // Widest operand zext() can handle; the caller narrows the result with a sized cast.
  localparam int unsigned ZEXT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Keep the low 'width' bits of d and force every bit above them to zero.
  function automatic logic [ZEXT_MAX_W-1:0] zext(input logic [ZEXT_MAX_W-1:0] d,
                                                 input int unsigned width);
    logic [ZEXT_MAX_W-1:0] mask;
    if (width >= ZEXT_MAX_W) mask = '1;
    else                     mask = (ZEXT_MAX_W'(1) << width) - ZEXT_MAX_W'(1);
    return d & mask;
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// acc_sat_add: combinational unsigned adder with carry-out.
//   a, b  : addends (Width bits)
//   sum_c : a + b, wrapped modulo 2^Width, or clamped to all ones on carry when ACC_SAT_EN is defined
//   carry_c : carry out of bit Width-1
// Build option: ACC_SAT_EN (defined = saturating sum, undefined = wrapping sum).
module acc_sat_add #(
  parameter int unsigned Width = 40
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] sum_c,
  output logic             carry_c
);

  logic [Width:0] full_c;

  assign full_c  = {1'b0, a} + {1'b0, b};
  assign carry_c = full_c[Width];

`ifdef ACC_SAT_EN
  // Once clamped, any further add with b>0 carries again, so the sum stays clamped.
  assign sum_c = carry_c ? {Width{1'b1}} : full_c[Width-1:0];
`else
  assign sum_c = full_c[Width-1:0];
`endif

endmodule

// File: rtl/fifo_acc_drain.sv
// fifo_acc_drain: pop-side controller that drains BurstLen words from a show-ahead FIFO,
// sums them and offers the sum downstream with a valid/ready handshake.
//   clk, aclr_n          : clock, asynchronous active-low reset
//   Start, BurstLen      : burst request (sampled only in IDLE)
//   Empty, DataOut, Pop  : FIFO read port (Pop is combinational)
//   Result, ResultValid, ResultReady : sum output handshake
//   Busy, Overflow       : status (DRAIN/HOLD, carry seen during burst)
// Build option: ACC_SAT_EN selects a saturating accumulator instead of a wrapping one.
module fifo_acc_drain
  import fifo_acc_drain_pkg::*;
#(
  parameter int unsigned DataWidth  = DATA_W_DEF,
  parameter int unsigned AccWidth   = ACC_W_DEF,
  parameter int unsigned CountWidth = COUNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  Start,
  input  logic [CountWidth-1:0] BurstLen,
  input  logic                  Empty,
  input  logic [DataWidth-1:0]  DataOut,
  output logic                  Pop,
  output logic [AccWidth-1:0]   Result,
  output logic                  ResultValid,
  input  logic                  ResultReady,
  output logic                  Busy,
  output logic                  Overflow
);

  state_t                state_q, state_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [CountWidth-1:0] rem_q, rem_d;
  logic [AccWidth-1:0]   result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  pop_c;

  logic [AccWidth-1:0]   data_ext_c;
  logic [AccWidth-1:0]   sum_c;
  logic                  carry_c;

  assign data_ext_c = AccWidth'(zext(ZEXT_MAX_W'(DataOut), DataWidth));

  acc_sat_add #(
    .Width (AccWidth)
  ) u_add (
    .a       (acc_q),
    .b       (data_ext_c),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, datapath updates and the combinational pop strobe.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    pop_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          ovf_d = 1'b0;
          if (BurstLen != '0) begin
            rem_d   = BurstLen;
            acc_d   = '0;
            state_d = DRAIN;
          end else begin
            // Zero-length burst: present an empty sum straight away.
            result_d = '0;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      DRAIN: begin
        pop_c = ~Empty;
        if (pop_c) begin
          acc_d = sum_c;
          rem_d = rem_q - CountWidth'(1);
          if (carry_c) ovf_d = 1'b1;
          if (rem_q == CountWidth'(1)) begin
            result_d = sum_c;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (ResultReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy is registered, so it is derived from the state being entered.
  assign busy_d = (state_d != IDLE);

  assign Pop         = pop_c;
  assign Result      = result_q;
  assign ResultValid = valid_q;
  assign Busy        = busy_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_acc_drain.sv
// tb_fifo_acc_drain: directed self-checking bench for fifo_acc_drain.
// Main instance uses default widths; a second 8/8-bit instance exercises the carry path.
module tb_fifo_acc_drain;

  logic clk = 1'b0;
  logic aclr_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main DUT (32/40/4) fed by a small show-ahead FIFO model.
  logic        start;
  logic [3:0]  burst_len;
  logic        empty;
  logic [31:0] data_out;
  logic        pop;
  logic [39:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        overflow;

  logic [31:0] mem [0:15];
  logic [7:0]  rd = 8'd0;
  logic [7:0]  wr = 8'd0;
  int          pops = 0;
  int          results = 0;

  assign empty    = (rd == wr);
  assign data_out = mem[rd[3:0]];

  always @(posedge clk) begin
    if (pop && !empty) begin
      rd   <= rd + 8'd1;
      pops <= pops + 1;
    end
    if (result_valid && result_ready) results <= results + 1;
  end

  fifo_acc_drain dut (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .Start       (start),
    .BurstLen    (burst_len),
    .Empty       (empty),
    .DataOut     (data_out),
    .Pop         (pop),
    .Result      (result),
    .ResultValid (result_valid),
    .ResultReady (result_ready),
    .Busy        (busy),
    .Overflow    (overflow)
  );

  // Narrow DUT (8/8/4), driven directly.
  logic       s_start;
  logic [3:0] s_burst_len;
  logic       s_empty;
  logic [7:0] s_data_out;
  logic       s_pop;
  logic [7:0] s_result;
  logic       s_result_valid;
  logic       s_result_ready;
  logic       s_busy;
  logic       s_overflow;

  fifo_acc_drain #(
    .DataWidth  (8),
    .AccWidth   (8),
    .CountWidth (4)
  ) dut_small (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .Start       (s_start),
    .BurstLen    (s_burst_len),
    .Empty       (s_empty),
    .DataOut     (s_data_out),
    .Pop         (s_pop),
    .Result      (s_result),
    .ResultValid (s_result_valid),
    .ResultReady (s_result_ready),
    .Busy        (s_busy),
    .Overflow    (s_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr[3:0]] = d;
    wr = wr + 8'd1;
  endtask

  int p0, r0;
  logic [7:0] exp_sat;

  initial begin
    aclr_n = 1'b0;
    start = 1'b0; burst_len = '0; result_ready = 1'b0;
    s_start = 1'b0; s_burst_len = '0; s_empty = 1'b1; s_data_out = '0; s_result_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #12;
    check("rst_pop",   64'(pop), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);
    aclr_n = 1'b1;
    tick();

    // Basic burst 1+2+3+4.
    p0 = pops; r0 = results;
    push(1); push(2); push(3); push(4);
    start = 1'b1; burst_len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_pop%0d", i), 64'(pop), 64'd1);
      check($sformatf("basic_busy%0d", i), 64'(busy), 64'd1);
      tick();
    end
    check("basic_valid", 64'(result_valid), 64'd1);
    check("basic_result", 64'(result), 64'd10);
    check("basic_ovf", 64'(overflow), 64'd0);
    check("basic_pop_after", 64'(pop), 64'd0);
    check("basic_pops", 64'(pops - p0), 64'd4);
    tick();
    check("basic_valid_hold", 64'(result_valid), 64'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("basic_valid_clr", 64'(result_valid), 64'd0);
    check("basic_idle", 64'(busy), 64'd0);
    check("basic_results", 64'(results - r0), 64'd1);

    // Stall: one word, three empty cycles, then two more words.
    p0 = pops;
    push(5);
    start = 1'b1; burst_len = 4'd3;
    tick();
    start = 1'b0;
    check("stall_pop_first", 64'(pop), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_nopop%0d", i), 64'(pop), 64'd0);
      check($sformatf("stall_busy%0d", i), 64'(busy), 64'd1);
      tick();
    end
    push(6); push(7);
    #1;
    check("stall_resume", 64'(pop), 64'd1);
    tick();
    tick();
    check("stall_valid", 64'(result_valid), 64'd1);
    check("stall_result", 64'(result), 64'd18);
    check("stall_pops", 64'(pops - p0), 64'd3);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Zero length with backpressure; Start held during HOLD must be ignored.
    p0 = pops;
    push(99);
    start = 1'b1; burst_len = 4'd0;
    #1;
    check("zero_pop_idle", 64'(pop), 64'd0);
    tick();
    burst_len = 4'd5;
    check("zero_valid", 64'(result_valid), 64'd1);
    check("zero_result", 64'(result), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), 64'(result_valid), 64'd1);
      check($sformatf("bp_result%0d", i), 64'(result), 64'd0);
      check($sformatf("bp_pop%0d", i), 64'(pop), 64'd0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("zero_valid_clr", 64'(result_valid), 64'd0);
    tick();
    check("zero_not_queued", 64'(busy), 64'd0);
    check("zero_pops", 64'(pops - p0), 64'd0);
    wr = rd;

    // Reset after two of four pops.
    push(11); push(12); push(13); push(14);
    start = 1'b1; burst_len = 4'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    aclr_n = 1'b0;
    #1;
    check("mrst_pop", 64'(pop), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_valid", 64'(result_valid), 64'd0);
    check("mrst_result", 64'(result), 64'd0);
    check("mrst_ovf", 64'(overflow), 64'd0);
    wr = rd;
    #2;
    aclr_n = 1'b1;
    tick();
    push(9); push(10);
    start = 1'b1; burst_len = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mrst_next_valid", 64'(result_valid), 64'd1);
    check("mrst_next_result", 64'(result), 64'd19);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Start held through DRAIN and HOLD.
    p0 = pops; r0 = results;
    push(20); push(21); push(22);
    start = 1'b1; burst_len = 4'd3;
    tick();
    burst_len = 4'd1;
    tick(); tick(); tick();
    check("busy_valid", 64'(result_valid), 64'd1);
    check("busy_result", 64'(result), 64'd63);
    tick();
    check("busy_result_hold", 64'(result), 64'd63);
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();
    check("busy_idle", 64'(busy), 64'd0);
    check("busy_pops", 64'(pops - p0), 64'd3);
    check("busy_results", 64'(results - r0), 64'd1);

    // Carry on the 8-bit instance: 200 + 100.
`ifdef ACC_SAT_EN
    exp_sat = 8'd255;
`else
    exp_sat = 8'd44;
`endif
    s_start = 1'b1; s_burst_len = 4'd2;
    tick();
    s_start = 1'b0;
    s_empty = 1'b0; s_data_out = 8'd200;
    #1;
    check("ovf_pop", 64'(s_pop), 64'd1);
    tick();
    s_data_out = 8'd100;
    tick();
    s_empty = 1'b1;
    check("ovf_valid", 64'(s_result_valid), 64'd1);
    check("ovf_result", 64'(s_result), 64'(exp_sat));
    check("ovf_flag", 64'(s_overflow), 64'd1);
    s_result_ready = 1'b1;
    tick();
    s_result_ready = 1'b0;
    s_start = 1'b1; s_burst_len = 4'd1;
    tick();
    s_start = 1'b0;
    check("ovf_cleared", 64'(s_overflow), 64'd0);
    s_empty = 1'b0; s_data_out = 8'd3;
    tick();
    s_empty = 1'b1;
    check("ovf_next_result", 64'(s_result), 64'd3);
    check("ovf_next_flag", 64'(s_overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
